// File: rtl/exchange_order_tx.sv
// exchange_order_tx
//   Producer end of the exchange order channel. Host orders are buffered in a
//   small FIFO and issued one at a time as single-cycle exchange_go strobes.
//   The processor's per-client permit (max_to_trade) and cancel
//   (cancelled_orders) masks decide, at the FIFO head, whether an order is
//   issued, held back, or discarded.
//
// Ports
//   clk, HRESETn          clock, asynchronous active-low reset
//   in_valid/in_ready     host order handshake (in_client_id, in_amount)
//   max_to_trade          bit c = 1: client c may trade
//   cancelled_orders      bit c = 1: orders for client c are discarded
//   exchange_go           one-cycle order strobe
//   exchange_client_id    registered id, qualified by exchange_go
//   exchange_amount       registered amount, qualified by exchange_go
//   fifo_level            current FIFO occupancy
//   sent_count            orders issued (saturating)
//   dropped_count         orders discarded (saturating)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | evaluate FIFO head: drop, stall, or pop and launch
// ST_ISSUE | exchange_go high for exactly one cycle, sent_count bumps
// ST_GAP   | GAP forced idle cycles (down-counter) before next evaluation

module exchange_order_tx #(
  parameter int DEPTH = 8,
  parameter int GAP   = 1,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    HRESETn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4:0]              in_client_id,
  input  logic [15:0]             in_amount,
  input  logic [31:0]             max_to_trade,
  input  logic [31:0]             cancelled_orders,
  output logic                    exchange_go,
  output logic [4:0]              exchange_client_id,
  output logic [15:0]             exchange_amount,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic [CNT_W-1:0]        sent_count,
  output logic [CNT_W-1:0]        dropped_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  // Loaded on ISSUE so the GAP state lasts exactly GAP cycles.
  localparam logic [3:0]       GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [4:0]       mem_id  [DEPTH];
  logic [15:0]      mem_amt [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [3:0]       gap_cnt;
  logic             rdy_en;

  logic             push, pop, drop, take;
  logic [4:0]       head_id;
  logic [15:0]      head_amt;

  assign head_id     = mem_id[rd_ptr];
  assign head_amt    = mem_amt[rd_ptr];
  // rdy_en keeps in_ready low while in reset and sets on the first edge after.
  assign in_ready    = rdy_en & (fifo_level != LVL_FULL);
  assign push        = in_valid & in_ready;
  assign exchange_go = (state_q == ST_ISSUE);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    drop    = 1'b0;
    take    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fifo_level != '0) begin
          // Cancel is checked first so it wins over a simultaneous permit.
          if (cancelled_orders[head_id] || (head_amt == 16'd0)) begin
            pop  = 1'b1;
            drop = 1'b1;
          end else if (max_to_trade[head_id]) begin
            pop     = 1'b1;
            take    = 1'b1;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (GAP != 0) state_d = ST_GAP;
        else          state_d = ST_IDLE;
      end
      ST_GAP: begin
        if (gap_cnt == 4'd0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      gap_cnt <= 4'd0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_ISSUE)                      gap_cnt <= GAP_LOAD;
      else if (state_q == ST_GAP && gap_cnt != '0)  gap_cnt <= gap_cnt - 4'd1;
    end
  end

  // Storage needs no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_id[wr_ptr]  <= in_client_id;
      mem_amt[wr_ptr] <= in_amount;
    end
  end

  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      rdy_en     <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_ONE;
        2'b01:   fifo_level <= fifo_level - LVL_ONE;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      exchange_client_id <= '0;
      exchange_amount    <= '0;
      sent_count         <= '0;
      dropped_count      <= '0;
    end else begin
      if (take) begin
        exchange_client_id <= head_id;
        exchange_amount    <= head_amt;
      end
      if (state_q == ST_ISSUE && sent_count != CNT_MAX)
        sent_count <= sent_count + CNT_ONE;
      if (drop && dropped_count != CNT_MAX)
        dropped_count <= dropped_count + CNT_ONE;
    end
  end

endmodule
